// File: rtl/shared_resource_mux_pkg.sv
// Shared widths and the round-robin pick used by the shared_resource_mux_n front end.
// The pick works on a fixed 16-wide request vector, so any channel count up to 16 can use it.
package shared_resource_mux_pkg;

    localparam int DEF_NUM_CH   = 4;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_DEPTH    = 4;

    localparam int MAX_CH       = 16;
    localparam int MAX_CH_IDX_W = 4;

    localparam int CH_IDX_W     = $clog2(DEF_NUM_CH);
    localparam int CNT_W        = $clog2(DEF_DEPTH + 1);
    localparam int PTR_W        = $clog2(DEF_DEPTH);

    // Returns {found, index}: the first set elig bit at or after ptr, wrapping modulo n.
    function automatic logic [MAX_CH_IDX_W:0] rr_pick(
        input logic [MAX_CH-1:0]       elig,
        input logic [MAX_CH_IDX_W-1:0] ptr,
        input int                      n
    );
        logic [MAX_CH_IDX_W:0] pick;
        int                    idx;
        pick = '0;
        for (int i = 0; i < MAX_CH; i++) begin
            idx = (int'(ptr) + i) % n;
            if ((i < n) && !pick[MAX_CH_IDX_W] && elig[idx]) begin
                pick = {1'b1, idx[MAX_CH_IDX_W-1:0]};
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/channel_fifo.sv
// Per-channel FIFO. Pointers wrap naturally because DEPTH is a power of two;
// flush returns the FIFO to its reset state in one cycle.
module channel_fifo
    import shared_resource_mux_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              enq,
    input  logic              deq,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              empty,
    output logic              full
);

    localparam int L_CNT_W = $clog2(DEPTH + 1);
    localparam int L_PTR_W = $clog2(DEPTH);
    localparam logic [L_PTR_W-1:0] PTR_ONE  = L_PTR_W'(1);
    localparam logic [L_CNT_W-1:0] CNT_ONE  = L_CNT_W'(1);
    localparam logic [L_CNT_W-1:0] CNT_FULL = L_CNT_W'(DEPTH);

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [L_PTR_W-1:0] r_wr_ptr;
    logic [L_PTR_W-1:0] r_rd_ptr;
    logic [L_CNT_W-1:0] r_count;
    logic               w_do_enq;
    logic               w_do_deq;

    assign empty    = (r_count == '0);
    assign full     = (r_count == CNT_FULL);
    assign dout     = r_mem[r_rd_ptr];
    assign w_do_enq = enq & ~full & ~flush;
    assign w_do_deq = deq & ~empty & ~flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_enq) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_do_deq) r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_do_enq, w_do_deq})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: ;
            endcase
        end
    end

    // Storage is not reset; the count and pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (reset && w_do_enq) r_mem[r_wr_ptr] <= din;
    end

endmodule

// File: rtl/shared_resource_mux_n.sv
// N-channel front end that time-shares one external combinational resource.
// Each channel: FIFO with empty-bypass, round-robin grant, registered result with stall/flush.
module shared_resource_mux_n
    import shared_resource_mux_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [NUM_CH-1:0]        in_flush,
    input  logic [NUM_CH-1:0]        in_stall,
    output logic [NUM_CH-1:0]        out_stall,
    output logic [NUM_CH-1:0]        out_valid,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic [NUM_CH-1:0]        out_flush,
    output logic [DATA_W-1:0]        res_in,
    input  logic [DATA_W-1:0]        res_out,
    output logic [NUM_CH-1:0]        grant
);

    // Handshake: a beat transfers on in_valid_i while out_stall_i is low; out_valid_i
    // holds with out_data_i while in_stall_i is high, and is consumed when in_stall_i is low.
    localparam int L_CH_IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0]       w_empty;
    logic [NUM_CH-1:0]       w_full;
    logic [NUM_CH-1:0]       w_req;
    logic [NUM_CH-1:0]       w_ready;
    logic [NUM_CH-1:0]       w_elig;
    logic [NUM_CH-1:0]       w_grant;
    logic [NUM_CH-1:0]       w_enq;
    logic [NUM_CH-1:0]       w_deq;
    logic [DATA_W-1:0]       w_fifo_dout [NUM_CH];
    logic [DATA_W-1:0]       w_head      [NUM_CH];
    logic [DATA_W-1:0]       w_res_in;
    logic [MAX_CH_IDX_W:0]   w_pick;
    logic [MAX_CH_IDX_W-1:0] w_pick_idx;

    logic [L_CH_IDX_W-1:0]   r_ptr;
    logic [NUM_CH-1:0]       r_out_valid;
    logic [NUM_CH-1:0]       r_out_flush;
    logic [DATA_W-1:0]       r_out_data [NUM_CH];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        channel_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .reset (reset),
            .flush (in_flush[g]),
            .enq   (w_enq[g]),
            .deq   (w_deq[g]),
            .din   (in_data[g*DATA_W +: DATA_W]),
            .dout  (w_fifo_dout[g]),
            .empty (w_empty[g]),
            .full  (w_full[g])
        );

        assign w_head[g] = w_empty[g] ? in_data[g*DATA_W +: DATA_W] : w_fifo_dout[g];
        assign out_data[g*DATA_W +: DATA_W] = r_out_data[g];
    end

    assign w_req   = in_valid | ~w_empty;
    assign w_ready = ~r_out_valid | ~in_stall;
    assign w_elig  = w_req & w_ready & ~in_flush;

    assign w_pick     = rr_pick(MAX_CH'(w_elig), MAX_CH_IDX_W'(r_ptr), NUM_CH);
    assign w_pick_idx = w_pick[MAX_CH_IDX_W-1:0];

    // Grant is masked by reset so nothing reaches the resource while reset is low.
    always_comb begin
        w_grant = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_grant[k] = reset & w_pick[MAX_CH_IDX_W] & (w_pick_idx == MAX_CH_IDX_W'(k));
        end
    end

    always_comb begin
        w_res_in = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (w_grant[k]) w_res_in = w_res_in | w_head[k];
        end
    end

    // A granted bypass beat goes straight to the resource and is never stored.
    assign w_enq = in_valid & ~w_full & ~in_flush & ~(w_grant & w_empty);
    assign w_deq = w_grant & ~w_empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr <= '0;
        end else if (|w_grant) begin
            r_ptr <= L_CH_IDX_W'((w_pick_idx == MAX_CH_IDX_W'(NUM_CH - 1)) ? '0
                                 : w_pick_idx + MAX_CH_IDX_W'(1));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_valid <= '0;
            r_out_flush <= '0;
            for (int i = 0; i < NUM_CH; i++) r_out_data[i] <= '0;
        end else begin
            r_out_flush <= in_flush;
            for (int i = 0; i < NUM_CH; i++) begin
                if (in_flush[i]) begin
                    r_out_valid[i] <= 1'b0;
                end else if (w_grant[i]) begin
                    r_out_data[i]  <= res_out;
                    r_out_valid[i] <= 1'b1;
                end else if (!in_stall[i]) begin
                    r_out_valid[i] <= 1'b0;
                end
            end
        end
    end

    assign out_stall = w_full;
    assign out_valid = r_out_valid;
    assign out_flush = r_out_flush;
    assign res_in    = w_res_in;
    assign grant     = w_grant;

endmodule

// File: tb/tb_shared_resource_mux_n.sv
// Bench for shared_resource_mux_n with a +1 resource and a cycle model of every channel.
module tb_shared_resource_mux_n;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;

    logic                     clk   = 1'b0;
    logic                     reset = 1'b0;
    logic [NUM_CH-1:0]        in_valid;
    logic [NUM_CH*DATA_W-1:0] in_data;
    logic [NUM_CH-1:0]        in_flush;
    logic [NUM_CH-1:0]        in_stall;
    logic [NUM_CH-1:0]        out_stall;
    logic [NUM_CH-1:0]        out_valid;
    logic [NUM_CH*DATA_W-1:0] out_data;
    logic [NUM_CH-1:0]        out_flush;
    logic [DATA_W-1:0]        res_in;
    logic [DATA_W-1:0]        res_out;
    logic [NUM_CH-1:0]        grant;

    shared_resource_mux_n #(
        .NUM_CH (NUM_CH),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_flush  (in_flush),
        .in_stall  (in_stall),
        .out_stall (out_stall),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_flush (out_flush),
        .res_in    (res_in),
        .res_out   (res_out),
        .grant     (grant)
    );

    assign res_out = res_in + DATA_W'(1);

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // Model: exp_q holds raw beats accepted into each FIFO, popped on grant.
    logic [DATA_W-1:0] exp_q [NUM_CH][$];
    logic [NUM_CH-1:0] m_out_v = '0;
    logic [NUM_CH-1:0] m_flush = '0;
    logic [DATA_W-1:0] m_out_d [NUM_CH];
    int                m_ptr = 0;

    always @(negedge clk) begin
        logic [NUM_CH-1:0] e_grant;
        logic [NUM_CH-1:0] m_empty;
        logic [NUM_CH-1:0] m_full;
        logic [NUM_CH-1:0] elig;
        logic [DATA_W-1:0] head  [NUM_CH];
        logic [DATA_W-1:0] ch_in [NUM_CH];
        logic [DATA_W-1:0] exp_res;
        int                gi;
        int                idx;
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                exp_q[i].delete();
                m_out_d[i] = '0;
            end
            m_out_v = '0;
            m_flush = '0;
            m_ptr   = 0;
            check("rst_grant", grant, 0);
            check("rst_res_in", res_in, 0);
            check("rst_out_stall", out_stall, 0);
            check("rst_out_valid", out_valid, 0);
            check("rst_out_flush", out_flush, 0);
            check("rst_out_data", {63'd0, |out_data}, 0);
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                ch_in[i]   = in_data[i*DATA_W +: DATA_W];
                m_empty[i] = (exp_q[i].size() == 0);
                m_full[i]  = (exp_q[i].size() == DEPTH);
                head[i]    = m_empty[i] ? ch_in[i] : exp_q[i][0];
                elig[i]    = (in_valid[i] | ~m_empty[i]) & (~m_out_v[i] | ~in_stall[i]) & ~in_flush[i];
                check($sformatf("out_data%0d", i), out_data[i*DATA_W +: DATA_W], m_out_d[i]);
            end
            check("out_valid", out_valid, m_out_v);
            check("out_flush", out_flush, m_flush);
            check("out_stall", out_stall, m_full);
            check("proto_full_drop", in_valid & out_stall, 0);

            e_grant = '0;
            gi      = -1;
            for (int k = 0; k < NUM_CH; k++) begin
                idx = (m_ptr + k) % NUM_CH;
                if (gi < 0 && elig[idx]) begin
                    gi           = idx;
                    e_grant[idx] = 1'b1;
                end
            end
            exp_res = '0;
            if (gi >= 0) exp_res = head[gi];
            check("grant", grant, e_grant);
            check("res_in", res_in, exp_res);

            m_flush = in_flush;
            for (int i = 0; i < NUM_CH; i++) begin
                if (in_flush[i]) begin
                    exp_q[i].delete();
                    m_out_v[i] = 1'b0;
                end else begin
                    if (e_grant[i]) begin
                        m_out_d[i] = head[i] + DATA_W'(1);
                        m_out_v[i] = 1'b1;
                        if (!m_empty[i]) void'(exp_q[i].pop_front());
                    end else if (!in_stall[i]) begin
                        m_out_v[i] = 1'b0;
                    end
                    if (in_valid[i] && !m_full[i] && !(e_grant[i] && m_empty[i]))
                        exp_q[i].push_back(ch_in[i]);
                end
            end
            if (gi >= 0) m_ptr = (gi + 1) % NUM_CH;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int ch, input logic [DATA_W-1:0] v);
        in_data[ch*DATA_W +: DATA_W] = v;
    endtask

    task automatic idle(input int n);
        in_valid = '0;
        repeat (n) tick();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int               gcnt [NUM_CH];
        logic [NUM_CH-1:0] prev_g;
        in_valid = '0;
        in_flush = '0;
        in_stall = '0;
        in_data  = '0;
        prev_g   = '0;
        for (int i = 0; i < NUM_CH; i++) gcnt[i] = 0;

        // Reset with requests present: grant and res_in must stay at zero.
        in_valid = '1;
        for (int i = 0; i < NUM_CH; i++) set_data(i, $urandom);
        repeat (3) tick();
        @(negedge clk);
        check("rst_gate_grant", grant, 0);
        check("rst_gate_res_in", res_in, 0);
        tick();
        in_valid = '0;
        reset    = 1'b1;
        tick();

        // Single bypass beat on channel 2.
        in_valid = 4'b0100;
        set_data(2, 32'h10);
        @(negedge clk);
        check("t1_grant", grant, 4'b0100);
        check("t1_res_in", res_in, 32'h10);
        tick();
        in_valid = '0;
        @(negedge clk);
        check("t1_out_valid2", out_valid[2], 1);
        check("t1_out_data2", out_data[2*DATA_W +: DATA_W], 32'h11);
        idle(3);

        // All channels requesting: grants rotate and each channel gets 2 of 8.
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                in_valid[i] = ~out_stall[i];
                set_data(i, $urandom);
            end
            @(negedge clk);
            for (int i = 0; i < NUM_CH; i++) if (grant[i]) gcnt[i]++;
            if (c > 0) check("rr_rotate", grant, {prev_g[NUM_CH-2:0], prev_g[NUM_CH-1]});
            prev_g = grant;
            tick();
        end
        for (int i = 0; i < NUM_CH; i++) check($sformatf("rr_fair%0d", i), gcnt[i], 2);
        idle(20);

        // Channel 0 stalled: one held result plus four queued beats fill the FIFO.
        in_stall = 4'b0001;
        in_valid = 4'b0001;
        set_data(0, 32'h50);
        tick();
        for (int j = 0; j < 4; j++) begin
            set_data(0, DATA_W'(j));
            tick();
        end
        in_valid = '0;
        @(negedge clk);
        check("t3_out_stall0", out_stall[0], 1);
        check("t3_held_valid0", out_valid[0], 1);
        check("t3_held_data0", out_data[DATA_W-1:0], 32'h51);
        repeat (3) tick();
        in_stall = '0;
        @(negedge clk);
        for (int j = 1; j <= 4; j++) begin
            tick();
            @(negedge clk);
            check("t3_order_valid", out_valid[0], 1);
            check("t3_order_data", out_data[DATA_W-1:0], DATA_W'(j));
        end
        tick();
        in_valid = 4'b0001;
        set_data(0, 32'h4);
        tick();
        in_valid = '0;
        @(negedge clk);
        check("t3_fifth", out_data[DATA_W-1:0], 32'h5);
        idle(3);

        // Channel 1 queues three beats, then is flushed while channel 3 keeps streaming.
        in_stall = 4'b0010;
        for (int c = 0; c < 4; c++) begin
            in_valid = 4'b1010;
            set_data(1, DATA_W'(32'h20 + c));
            set_data(3, DATA_W'(32'h300 + c));
            tick();
        end
        in_flush = 4'b0010;
        set_data(1, 32'h99);
        set_data(3, 32'h304);
        @(negedge clk);
        check("t4_flush_nogrant", grant[1], 0);
        tick();
        in_flush = '0;
        in_valid = 4'b1000;
        set_data(3, 32'h305);
        @(negedge clk);
        check("t4_out_flush1", out_flush[1], 1);
        check("t4_out_valid1", out_valid[1], 0);
        check("t4_out_stall1", out_stall[1], 0);
        check("t4_ch3_valid", out_valid[3], 1);
        tick();
        in_stall = '0;
        for (int c = 0; c < 3; c++) begin
            set_data(3, DATA_W'(32'h306 + c));
            @(negedge clk);
            if (c == 0) check("t4_out_flush1_drop", out_flush[1], 0);
            check("t4_ch1_empty", grant[1], 0);
            check("t4_ch3_valid", out_valid[3], 1);
            tick();
        end
        idle(4);

        // Channel 0 held at DEPTH-1 entries with one enqueue and one dequeue per cycle.
        in_stall = 4'b0001;
        in_valid = 4'b0001;
        for (int c = 0; c < 4; c++) begin
            set_data(0, DATA_W'(32'h40 + c));
            tick();
        end
        in_stall = '0;
        for (int c = 0; c < 2 * DEPTH; c++) begin
            set_data(0, DATA_W'(32'h44 + c));
            @(negedge clk);
            check("t5_no_stall", out_stall[0], 0);
            check("t5_grant0", grant[0], 1);
            tick();
        end
        idle(6);

        // Reset mid-burst with channels 0 and 2 holding data and ptr at 2.
        in_stall = 4'b0101;
        for (int c = 0; c < 3; c++) begin
            in_valid = 4'b0101;
            set_data(0, DATA_W'(32'h60 + c));
            set_data(2, DATA_W'(32'h70 + c));
            tick();
        end
        in_valid = 4'b0010;
        set_data(1, 32'h80);
        @(negedge clk);
        check("t6_grant1", grant, 4'b0010);
        tick();
        in_valid = '0;
        reset    = 1'b0;
        #1;
        check("t6_rst_valid", out_valid, 0);
        check("t6_rst_stall", out_stall, 0);
        check("t6_rst_flush", out_flush, 0);
        check("t6_rst_grant", grant, 0);
        check("t6_rst_res_in", res_in, 0);
        check("t6_rst_data", {63'd0, |out_data}, 0);
        repeat (2) tick();
        reset    = 1'b1;
        in_stall = '0;
        in_valid = 4'b0101;
        set_data(0, 32'hA0);
        set_data(2, 32'hA2);
        @(negedge clk);
        check("t6_first_grant", grant, 4'b0001);
        tick();
        idle(6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/shared_resource_mux_n.md
# shared_resource_mux_n

- Parametrised N-channel front end for one combinational shared resource.
- Each channel has:
  - a DEPTH-entry input FIFO with empty-bypass;
  - a registered output stage with valid/stall/flush handshake.
- A fair round-robin arbiter grants the resource to one channel per cycle.
- The resource function is external: this block drives its input and captures its output, so one block serves any DATA_W-wide resource in the pipeline.

## Interface
- NUM_CH, 4: channel count, 2..16.
- DATA_W, 32: datapath width.
- DEPTH, 4: per-channel FIFO entries; power of two, ≥2.
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low; all state cleared while low.
- in_valid  in  NUM_CH  per-channel input valid.
- in_data  in  NUM_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
- in_flush  in  NUM_CH  per-channel flush request.
- in_stall  in  NUM_CH  downstream stall for channel i's output register.
- out_stall  in  —  (none; see below)
- out_stall  out  NUM_CH  channel FIFO full; upstream must hold off.
- out_valid  out  NUM_CH  registered result valid.
- out_data  out  NUM_CH*DATA_W  registered results, same packing as in_data.
- out_flush  out  NUM_CH  in_flush delayed one cycle.
- res_in  out  DATA_W  operand to the shared resource; 0 when no grant.
- res_out  in  DATA_W  resource result, combinational from res_in.
- grant  out  NUM_CH  one-hot (or zero) grant this cycle.

## Operation
- Head data:
  - head_i = in_data_i when FIFO_i is empty (bypass);
  - otherwise head_i = FIFO_i front.
- Request and readiness:
  - req_i = in_valid_i | !empty_i.
  - ready_i = !out_valid_i | !in_stall_i.
- Eligibility: elig_i = req_i & ready_i & !in_flush_i.
- Arbitration:
  - Round-robin over elig, searching from pointer ptr.
  - At most one grant per cycle.
  - When grant_k fires, ptr <= (k+1) mod NUM_CH.
  - With no grant, ptr holds.
- Resource input: res_in = head of the granted channel.
- Fire (grant_i):
  - out_data_i <= res_out;
  - out_valid_i <= 1;
  - if FIFO_i is non-empty, dequeue its front.
- No fire:
  - if !in_stall_i, out_valid_i <= 0;
  - otherwise out_valid_i and out_data_i hold.
- Enqueue condition: in_valid_i & !full_i & !in_flush_i & !(grant_i & empty_i).
  - A granted bypass is consumed directly and is not stored.
- in_valid_i while full_i: the beat is dropped. This is a protocol violation; the bench flags it.
- Simultaneous enqueue and dequeue: count unchanged, order preserved (FIFO).
- Flush (in_flush_i = 1):
  - FIFO_i cleared (count 0, pointers 0);
  - out_valid_i <= 0;
  - channel i ineligible and in_valid_i ignored that cycle;
  - out_flush_i <= 1 next cycle.
- Flush is independent per channel; other channels are unaffected.
- Arithmetic:
  - count width $clog2(DEPTH+1);
  - read/write pointers $clog2(DEPTH) bits, wrap naturally;
  - full_i = (count_i == DEPTH).

## Timing
- Reset values:
  - out_valid, out_flush, out_data, FIFO counts and pointers = 0;
  - ptr = 0, so channel 0 has first priority.
- Combinational outputs during reset:
  - out_stall = 0;
  - grant = 0;
  - res_in = 0.
- Latency:
  - bypass fire in cycle t → out_valid_i and out_data_i at t+1;
  - a queued entry waits for grant, minimum 1 cycle after it becomes head.
- out_stall_i reflects the registered count only. A deq in the same cycle does not lower it until the next cycle.
- Fairness: with all NUM_CH channels continuously eligible, each is granted exactly once every NUM_CH cycles.
- Reset asserted mid-operation:
  - all state cleared immediately (async);
  - queued data is lost;
  - the first grant after deassertion goes to the lowest eligible index.
- Throughput: total one result per cycle across all channels.

## Structure
- Package shared_resource_mux_pkg holds:
  - CH_IDX_W = $clog2(NUM_CH);
  - CNT_W;
  - PTR_W;
  - a function for round-robin next-grant.
- Sub-module channel_fifo:
  - parameters DATA_W and DEPTH;
  - ports: clk, reset, flush, enq, deq, din, dout, empty, full;
  - instantiated NUM_CH times via generate.
- Arbiter, output registers and res_in mux are inline.

## Test plan
- NUM_CH=4, resource = +1, a single beat on channel 2 (in_data=0x10), all idle → grant=0100 at t, out_valid_2=1 with out_data_2=0x11 at t+1.
- All 4 channels valid every cycle, no stall → grants cycle 0001,0010,0100,1000,0001; each out_valid pulses once per 4 cycles.
- Channel 0 in_stall=1 with out_valid_0 held, 5 beats sent → FIFO fills to 4, out_stall_0=1 after 4th enqueue; release stall → results emerge in order 1..4.
- Channel 1 holding 3 queued entries, in_flush_1 pulse → count_1=0 next cycle, out_flush_1=1 for one cycle, out_valid_1=0, channel 3 traffic uninterrupted.
- FIFO at DEPTH-1 with simultaneous enq and deq for 2*DEPTH cycles → count constant, pointer wrap verified, data order preserved.
- Reset asserted low mid-burst (FIFOs non-empty, ptr=2) → all outputs 0 immediately; after release, the first grant goes to channel 0 when channels 0 and 2 request.
